// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//   Bundles the signals exchanged between the program sequencer, the
//   testbench/top level and the instruction fetch stage.
//
//   Signals:
//     Start       request level, a rising edge asks for a run
//     ProgSel     program select (00/01/10, 11 = all three in order)
//     Halt        completion flag from the fetch stage
//     Init        fetch-stage Init
//     ProgState   fetch-stage program select
//     Busy        sequencer is in LOAD or RUN
//     Done        sequencer finished its last run
//     Timeout     sticky, the last run was aborted by the watchdog
//     CycleCount  RUN cycles since the last accepted Start (saturating)
//
//   Modports:
//     master  drives the requests and Halt (testbench / top level side)
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic [1:0]       ProgSel;
    logic             Halt;
    logic             Init;
    logic [1:0]       ProgState;
    logic             Busy;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, ProgSel, Halt,
        input  Init, ProgState, Busy, Done, Timeout, CycleCount
    );

    modport slave (
        input  Start, ProgSel, Halt,
        output Init, ProgState, Busy, Done, Timeout, CycleCount
    );
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Program-level controller sitting in front of the instruction fetch stage.
//   On a Start rising edge it selects a program, holds the fetch stage in
//   Init for INIT_CYCLES cycles, releases it and waits for Halt. With
//   ProgSel = 11 the three programs 00, 01, 10 are run back to back.
//   A per-program watchdog (MAX_CYCLES, 0 = off) aborts a hung program.
//
//   Ports:
//     CLK      clock, all state changes on the rising edge
//     Reset_n  asynchronous active-low reset
//     bus      prog_sequencer_if.slave (Start/ProgSel/Halt in,
//              Init/ProgState/Busy/Done/Timeout/CycleCount out)
//
//   All outputs come straight from flops; there is no combinational path
//   from any input to any output.
// ---------------------------------------------------------------------------
module prog_sequencer #(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_CYCLES  = 4096,
    parameter int CNT_W       = 16
) (
    input  logic            CLK,
    input  logic            Reset_n,
    prog_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int               LW        = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
    localparam logic [LW-1:0]    LOAD_LAST = LW'(INIT_CYCLES - 1);
    localparam logic [CNT_W:0]   WD_LIMIT  = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q;
    logic             start_q;
    logic             run_all_q;
    logic             init_q;
    logic [1:0]       prog_state_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] prog_cnt_q;
    logic [LW-1:0]    load_cnt_q;

    logic             start_edge;
    logic             halt_ok;
    logic             wd_hit;
    logic [CNT_W:0]   prog_nxt_w;
    logic [CNT_W-1:0] prog_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_d;

    assign start_edge = bus.Start & ~start_q;

    // Halt from the fetch stage is stale in the first RUN cycle after Init,
    // which is exactly the cycle where the per-program counter is still 0.
    assign halt_ok    = (prog_cnt_q != '0);

    // Watchdog fires at the end of RUN cycle number MAX_CYCLES; compared one
    // bit wider so a limit of 2**CNT_W is still reachable.
    assign prog_nxt_w = {1'b0, prog_cnt_q} + (CNT_W + 1)'(1);
    assign wd_hit     = (MAX_CYCLES != 0) && (prog_nxt_w == WD_LIMIT);

    // Both counters saturate rather than wrap.
    assign prog_cnt_d = (prog_cnt_q == CNT_MAX) ? prog_cnt_q : prog_cnt_q + CNT_W'(1);
    assign cyc_cnt_d  = (cyc_cnt_q  == CNT_MAX) ? cyc_cnt_q  : cyc_cnt_q  + CNT_W'(1);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b1;   // a Start held through reset is not an edge
            run_all_q    <= 1'b0;
            init_q       <= 1'b1;
            prog_state_q <= 2'b11;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cyc_cnt_q    <= '0;
            prog_cnt_q   <= '0;
            load_cnt_q   <= '0;
        end else begin
            start_q <= bus.Start;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        run_all_q    <= (bus.ProgSel == 2'b11);
                        prog_state_q <= (bus.ProgSel == 2'b11) ? 2'b00 : bus.ProgSel;
                        cyc_cnt_q    <= '0;
                        prog_cnt_q   <= '0;
                        load_cnt_q   <= '0;
                        timeout_q    <= 1'b0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        init_q       <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    prog_cnt_q <= '0;
                    if (load_cnt_q == LOAD_LAST) begin
                        init_q  <= 1'b0;
                        state_q <= S_RUN;
                    end else begin
                        load_cnt_q <= load_cnt_q + LW'(1);
                    end
                end

                S_RUN: begin
                    prog_cnt_q <= prog_cnt_d;
                    cyc_cnt_q  <= cyc_cnt_d;
                    // Halt is checked first so it wins over a same-cycle expiry.
                    if (halt_ok && bus.Halt) begin
                        if (run_all_q && (prog_state_q != 2'b10)) begin
                            prog_state_q <= prog_state_q + 2'b01;
                            load_cnt_q   <= '0;
                            init_q       <= 1'b1;
                            state_q      <= S_LOAD;
                        end else begin
                            init_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (wd_hit) begin
                        // Abort skips any remaining programs of a run-all.
                        timeout_q <= 1'b1;
                        init_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Init       = init_q;
    assign bus.ProgState  = prog_state_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Timeout    = timeout_q;
    assign bus.CycleCount = cyc_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//   Directed bench for prog_sequencer. Two instances share clock and reset:
//   dut_a with the default watchdog (4096) and dut_w with MAX_CYCLES = 8.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   that same point, i.e. after the flops have settled.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

    logic   CLK = 1'b0;
    logic   Reset_n;
    integer errs   = 0;
    integer checks = 0;

    always #5 CLK = ~CLK;

    prog_sequencer_if #(.CNT_W(16)) ia ();
    prog_sequencer_if #(.CNT_W(16)) iw ();

    prog_sequencer #(.INIT_CYCLES(2), .MAX_CYCLES(4096), .CNT_W(16)) dut_a (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (ia.slave)
    );

    prog_sequencer #(.INIT_CYCLES(2), .MAX_CYCLES(8), .CNT_W(16)) dut_w (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (iw.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stay in RUN for n cycles with Halt raised in the n-th one.
    // Called right after the edge that entered RUN.
    task automatic halt_a_after(input int n);
        repeat (n - 1) tick();
        ia.Halt = 1'b1;
        tick();
        ia.Halt = 1'b0;
    endtask

    // Fresh Start edge on ia, ending just after the edge that enters RUN.
    task automatic start_a(input logic [1:0] sel);
        ia.Start = 1'b0;
        tick();
        ia.Start   = 1'b1;
        ia.ProgSel = sel;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        ia.Start   = 1'b1;
        ia.ProgSel = 2'b01;
        ia.Halt    = 1'b0;
        iw.Start   = 1'b0;
        iw.ProgSel = 2'b00;
        iw.Halt    = 1'b0;
        tick();
        tick();
        checks++; if (ia.Init !== 1'b1) begin errs++; $display("FAIL rst_init: got %0b want 1", ia.Init); end
        checks++; if (ia.ProgState !== 2'b11) begin errs++; $display("FAIL rst_progstate: got %0b want 11", ia.ProgState); end
        checks++; if ({ia.Busy, ia.Done, ia.Timeout} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %03b want 000", {ia.Busy, ia.Done, ia.Timeout}); end
        checks++; if (ia.CycleCount !== 16'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", ia.CycleCount); end
        Reset_n = 1'b1;
        repeat (3) tick();
        // Start was high through reset: must not be taken as a request.
        checks++; if ({ia.Busy, ia.Init, ia.ProgState} !== 4'b0111) begin errs++; $display("FAIL rst_held_start: got busy/init/ps %04b want 0111", {ia.Busy, ia.Init, ia.ProgState}); end
        ia.Start = 1'b0;
        tick();
        ia.Start = 1'b1;
        tick();
        checks++; if ({ia.Busy, ia.ProgState} !== 3'b101) begin errs++; $display("FAIL rst_restart: got busy/ps %03b want 101", {ia.Busy, ia.ProgState}); end
        tick();
        tick();
        halt_a_after(2);
        checks++; if ({ia.Done, ia.CycleCount} !== {1'b1, 16'd2}) begin errs++; $display("FAIL rst_first_run: got done=%0b cnt=%0d want done=1 cnt=2", ia.Done, ia.CycleCount); end
    endtask

    task automatic test_single();
        ia.Start = 1'b0;
        tick();
        ia.Start   = 1'b1;
        ia.ProgSel = 2'b01;
        tick();
        checks++; if ({ia.Busy, ia.Done, ia.Init, ia.ProgState} !== 5'b10101) begin errs++; $display("FAIL single_load1: got busy/done/init/ps %05b want 10101", {ia.Busy, ia.Done, ia.Init, ia.ProgState}); end
        ia.ProgSel = 2'b10;  // must not affect the run in progress
        tick();
        checks++; if (ia.Init !== 1'b1) begin errs++; $display("FAIL single_load2: init got %0b want 1", ia.Init); end
        tick();
        checks++; if ({ia.Init, ia.Busy} !== 2'b01) begin errs++; $display("FAIL single_run_entry: init/busy got %02b want 01", {ia.Init, ia.Busy}); end
        halt_a_after(10);
        checks++; if ({ia.Done, ia.Busy, ia.Timeout, ia.Init} !== 4'b1001) begin errs++; $display("FAIL single_done: done/busy/to/init got %04b want 1001", {ia.Done, ia.Busy, ia.Timeout, ia.Init}); end
        checks++; if (ia.CycleCount !== 16'd10) begin errs++; $display("FAIL single_count: got %0d want 10", ia.CycleCount); end
        checks++; if (ia.ProgState !== 2'b01) begin errs++; $display("FAIL single_progstate: got %0b want 01", ia.ProgState); end
    endtask

    task automatic test_run_all();
        start_a(2'b11);
        checks++; if ({ia.ProgState, ia.Init} !== 3'b000) begin errs++; $display("FAIL all_p0: ps/init got %03b want 000", {ia.ProgState, ia.Init}); end
        halt_a_after(5);
        checks++; if ({ia.ProgState, ia.Init, ia.Busy, ia.Done} !== 5'b01110) begin errs++; $display("FAIL all_step1: ps/init/busy/done got %05b want 01110", {ia.ProgState, ia.Init, ia.Busy, ia.Done}); end
        tick();
        checks++; if (ia.Init !== 1'b1) begin errs++; $display("FAIL all_step1_init2: got %0b want 1", ia.Init); end
        tick();
        checks++; if (ia.Init !== 1'b0) begin errs++; $display("FAIL all_p1_run: init got %0b want 0", ia.Init); end
        halt_a_after(7);
        checks++; if ({ia.ProgState, ia.Init} !== 3'b101) begin errs++; $display("FAIL all_step2: ps/init got %03b want 101", {ia.ProgState, ia.Init}); end
        tick();
        tick();
        halt_a_after(3);
        checks++; if ({ia.Done, ia.Busy, ia.ProgState} !== 4'b1010) begin errs++; $display("FAIL all_done: done/busy/ps got %04b want 1010", {ia.Done, ia.Busy, ia.ProgState}); end
        checks++; if (ia.CycleCount !== 16'd15) begin errs++; $display("FAIL all_count: got %0d want 15", ia.CycleCount); end
    endtask

    task automatic test_watchdog();
        for (int pass = 0; pass < 2; pass++) begin
            iw.Start = 1'b0;
            tick();
            iw.Start   = 1'b1;
            iw.ProgSel = 2'b10;
            tick();
            checks++; if (iw.Timeout !== 1'b0) begin errs++; $display("FAIL wd_clear%0d: timeout got %0b want 0", pass, iw.Timeout); end
            tick();
            tick();
            repeat (7) tick();
            checks++; if ({iw.Busy, iw.Done} !== 2'b10) begin errs++; $display("FAIL wd_cycle8_%0d: busy/done got %02b want 10", pass, {iw.Busy, iw.Done}); end
            iw.Halt = (pass == 1);
            tick();
            iw.Halt = 1'b0;
            checks++; if ({iw.Done, iw.Busy, iw.Timeout} !== {2'b10, (pass == 0)}) begin errs++; $display("FAIL wd_end%0d: done/busy/to got %03b want %03b", pass, {iw.Done, iw.Busy, iw.Timeout}, {2'b10, (pass == 0)}); end
            checks++; if ({iw.CycleCount, iw.ProgState} !== {16'd8, 2'b10}) begin errs++; $display("FAIL wd_count%0d: cnt=%0d ps=%0b want cnt=8 ps=10", pass, iw.CycleCount, iw.ProgState); end
        end
    endtask

    task automatic test_first_halt();
        start_a(2'b00);
        ia.Halt = 1'b1;      // first RUN cycle: stale Halt
        tick();
        ia.Halt = 1'b0;
        checks++; if ({ia.Busy, ia.Done} !== 2'b10) begin errs++; $display("FAIL first_halt_ignored: busy/done got %02b want 10", {ia.Busy, ia.Done}); end
        ia.Start = 1'b0;
        tick();
        ia.Start   = 1'b1;   // edge during RUN: ignored and not queued
        ia.ProgSel = 2'b01;
        tick();
        ia.Halt = 1'b1;
        tick();
        ia.Halt = 1'b0;
        checks++; if ({ia.Done, ia.CycleCount, ia.ProgState} !== {1'b1, 16'd4, 2'b00}) begin errs++; $display("FAIL first_halt_done: done=%0b cnt=%0d ps=%0b want done=1 cnt=4 ps=00", ia.Done, ia.CycleCount, ia.ProgState); end
        tick();
        tick();
        checks++; if ({ia.Done, ia.Busy} !== 2'b10) begin errs++; $display("FAIL run_start_not_queued: done/busy got %02b want 10", {ia.Done, ia.Busy}); end
    endtask

    task automatic test_async_reset();
        start_a(2'b10);
        repeat (3) tick();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if ({ia.Init, ia.ProgState, ia.Busy, ia.Done, ia.Timeout} !== 6'b111000) begin errs++; $display("FAIL async_rst_outputs: init/ps/busy/done/to got %06b want 111000", {ia.Init, ia.ProgState, ia.Busy, ia.Done, ia.Timeout}); end
        checks++; if (ia.CycleCount !== 16'd0) begin errs++; $display("FAIL async_rst_count: got %0d want 0", ia.CycleCount); end
        tick();
        Reset_n = 1'b1;
        tick();
        checks++; if (ia.Busy !== 1'b0) begin errs++; $display("FAIL async_rst_no_start: busy got %0b want 0", ia.Busy); end
        start_a(2'b01);
        halt_a_after(3);
        checks++; if ({ia.Done, ia.CycleCount} !== {1'b1, 16'd3}) begin errs++; $display("FAIL async_rst_fresh: done=%0b cnt=%0d want done=1 cnt=3", ia.Done, ia.CycleCount); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_run_all();
        test_watchdog();
        test_first_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
